// File: rtl/mmc_sector_read_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mmc_sector_read_sequencer : reads N card sectors and streams their buffer words. Rev 1.0
// ============================================================================
module mmc_sector_read_sequencer #(
  parameter int P_WORDS_PER_SECTOR = 128,
  parameter int P_COUNT_W          = 8
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iSTART_REQ,
  output logic                 oSTART_BUSY,
  input  logic [31:0]          iSTART_ADDR,
  input  logic [P_COUNT_W-1:0] iSTART_COUNT,
  output logic                 oDONE_VALID,
  output logic                 oDONE_ERROR,
  output logic [5:0]           oDONE_FLAGS,
  output logic                 oDATA_VALID,
  output logic [31:0]          oDATA,
  input  logic                 iDATA_READY,
  output logic                 oMMC_CMD_REQ,
  input  logic                 iMMC_CMD_BUSY,
  output logic [2:0]           oMMC_CMD_COMMAND,
  output logic [31:0]          oMMC_CMD_ADDR,
  output logic [31:0]          oMMC_CMD_DATA,
  input  logic                 iMMC_OUT_VALID,
  input  logic [31:0]          iMMC_OUT_DATA,
  input  logic                 iMMC_OUT_ERROR,
  input  logic [5:0]           iMMC_OUT_FLAGS
);

  localparam int IDX_W = (P_WORDS_PER_SECTOR > 1) ? $clog2(P_WORDS_PER_SECTOR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_WORDS_PER_SECTOR - 1);
  localparam logic [2:0] CMD_READ_CARD = 3'd1;
  localparam logic [2:0] CMD_READ_BUF  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CARD_REQ  = 3'd1,
    S_CARD_WAIT = 3'd2,
    S_BUF_REQ   = 3'd3,
    S_BUF_WAIT  = 3'd4,
    S_DATA_OUT  = 3'd5,
    S_NEXT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [P_COUNT_W-1:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            data_q, data_d;
  logic                   done_error_q, done_error_d;
  logic [5:0]             done_flags_q, done_flags_d;
  logic                   cmd_req;
  logic [2:0]             cmd_command;
  logic [31:0]            cmd_addr;

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      done_error_q <= 1'b0;
      done_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      done_error_q <= done_error_d;
      done_flags_q <= done_flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    data_d       = data_q;
    done_error_d = done_error_q;
    done_flags_d = done_flags_q;
    cmd_req      = 1'b0;
    cmd_command  = 3'd0;
    cmd_addr     = '0;
    case (state_q)
      S_IDLE: begin
        if (iSTART_REQ) begin
          addr_d       = iSTART_ADDR;
          remaining_d  = iSTART_COUNT;
          idx_d        = '0;
          done_error_d = 1'b0;
          done_flags_d = '0;
          state_d      = (iSTART_COUNT == '0) ? S_DONE : S_CARD_REQ;
        end
      end
      S_CARD_REQ: begin
        cmd_command = CMD_READ_CARD;
        cmd_addr    = addr_q;
        if (!iMMC_CMD_BUSY) begin
          cmd_req = 1'b1;
          state_d = S_CARD_WAIT;
        end
      end
      S_CARD_WAIT: begin
        if (iMMC_OUT_VALID) begin
          if (iMMC_OUT_ERROR) begin
            done_flags_d = iMMC_OUT_FLAGS;
            done_error_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            idx_d   = '0;
            state_d = S_BUF_REQ;
          end
        end
      end
      S_BUF_REQ: begin
        // Buffer word address is the byte offset of the word inside the sector buffer.
        cmd_command = CMD_READ_BUF;
        cmd_addr    = {{(32-IDX_W-2){1'b0}}, idx_q, 2'b00};
        if (!iMMC_CMD_BUSY) begin
          cmd_req = 1'b1;
          state_d = S_BUF_WAIT;
        end
      end
      S_BUF_WAIT: begin
        if (iMMC_OUT_VALID) begin
          data_d  = iMMC_OUT_DATA;
          state_d = S_DATA_OUT;
        end
      end
      S_DATA_OUT: begin
        if (iDATA_READY) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == LAST_IDX) ? S_NEXT : S_BUF_REQ;
        end
      end
      S_NEXT: begin
        remaining_d = remaining_q - 1'b1;
        addr_d      = addr_q + 32'd512;
        state_d     = (remaining_q > P_COUNT_W'(1)) ? S_CARD_REQ : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign oSTART_BUSY      = (state_q != S_IDLE);
  assign oDONE_VALID      = (state_q == S_DONE);
  assign oDONE_ERROR      = done_error_q;
  assign oDONE_FLAGS      = done_flags_q;
  assign oDATA_VALID      = (state_q == S_DATA_OUT);
  assign oDATA            = data_q;
  assign oMMC_CMD_REQ     = cmd_req;
  assign oMMC_CMD_COMMAND = cmd_command;
  assign oMMC_CMD_ADDR    = cmd_addr;
  assign oMMC_CMD_DATA    = 32'd0;

endmodule
`default_nettype wire
